uart_cmd_ctrl: RTL and testbench

// - Command sequencer between the UART receiver and the board outputs (LED bank). Parses framed

---
 rtl/uart_cmd_pkg.sv | 37 +++
 rtl/uart_cmd_ctrl_if.sv | 30 +++
 rtl/uart_byte_strobe.sv | 27 ++
 rtl/uart_cmd_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// +----------------------------------------------------------------------+
// | uart_cmd_pkg                                                         |
// | Byte, opcode and state definitions for the UART command sequencer.   |
// | Build option: CMD_READBACK_EN adds the readback reply states.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_cmd_pkg;

  localparam logic [7:0] SOF_BYTE  = 8'hAA;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  localparam logic [7:0] OP_TOGGLE = 8'h55;
  localparam logic [7:0] OP_SET    = 8'h01;
  localparam logic [7:0] OP_CLR    = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_GET_OPC  = 4'd1,
    ST_GET_ARG  = 4'd2,
    ST_GET_CHK  = 4'd3,
    ST_EXEC     = 4'd4,
    ST_TX_REQ   = 4'd5,
    ST_TX_WAIT  = 4'd6
`ifdef CMD_READBACK_EN
    ,
    ST_TX_REQ2  = 4'd7,
    ST_TX_WAIT2 = 4'd8
`endif
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_cmd_ctrl_if.sv
// +----------------------------------------------------------------------+
// | uart_cmd_ctrl_if                                                     |
// | UART byte handshake and LED bank bundle for the command sequencer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface uart_cmd_ctrl_if #(
  parameter int N_LED = 4
);
  logic             rx_done_flag;
  logic [7:0]       rx_data;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic [N_LED-1:0] led;
  logic             frame_err;

  modport master (
    input  rx_done_flag, rx_data, tx_busy,
    output tx_start, tx_data, led, frame_err
  );

  modport slave (
    output rx_done_flag, rx_data, tx_busy,
    input  tx_start, tx_data, led, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_byte_strobe.sv
// +----------------------------------------------------------------------+
// | uart_byte_strobe                                                     |
// | Rising-edge detector on the receiver byte-done level.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_byte_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic flag,
  output logic strobe
);

  logic r_flag_q;

  // Resets high so a flag already asserted at reset release is not a byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_flag_q <= 1'b1;
    else        r_flag_q <= flag;
  end

  assign strobe = flag & ~r_flag_q;

endmodule

`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
// +----------------------------------------------------------------------+
// | uart_cmd_ctrl                                                        |
// | Parses SOF/OPC/ARG/CHK frames, drives the LED bank, replies ACK/NAK. |
// | Build option: CMD_READBACK_EN enables OP_READ second reply byte.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int N_LED          = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_cmd_ctrl_if.master       bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic [N_LED-1:0] r_led;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;
  logic             r_frame_err;
  logic [7:0]       r_opc;
  logic [7:0]       r_arg;
  logic [7:0]       r_reply;
  logic [CNT_W-1:0] r_cnt;
`ifdef CMD_READBACK_EN
  logic             r_readback;
`endif

  logic w_strobe;
  logic w_in_get;
  logic w_timeout;

  uart_byte_strobe u_strobe (
    .clk    (clk),
    .rst_n  (rst_n),
    .flag   (bus.rx_done_flag),
    .strobe (w_strobe)
  );

  assign w_in_get  = (r_state == ST_GET_OPC) || (r_state == ST_GET_ARG) ||
                     (r_state == ST_GET_CHK);
  assign w_timeout = w_in_get && !w_strobe && (r_cnt == CNT_LAST);

  // Inter-byte gap counter, live only while a frame is being collected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_cnt <= '0;
    else if (w_in_get && !w_strobe && !w_timeout) r_cnt <= r_cnt + CNT_W'(1);
    else                                        r_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_led       <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_frame_err <= 1'b0;
      r_opc       <= 8'h00;
      r_arg       <= 8'h00;
      r_reply     <= 8'h00;
`ifdef CMD_READBACK_EN
      r_readback  <= 1'b0;
`endif
    end else begin
      r_tx_start  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_strobe && (bus.rx_data == SOF_BYTE)) r_state <= ST_GET_OPC;
        end
        ST_GET_OPC: begin
          if (w_strobe) begin
            r_opc   <= bus.rx_data;
            r_state <= ST_GET_ARG;
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_GET_ARG: begin
          if (w_strobe) begin
            r_arg   <= bus.rx_data;
            r_state <= ST_GET_CHK;
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_GET_CHK: begin
          if (w_strobe) begin
            if (bus.rx_data == (r_opc ^ r_arg)) begin
              r_state <= ST_EXEC;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_reply <= ACK_BYTE;
          r_state <= ST_TX_REQ;
          case (r_opc)
            OP_TOGGLE: begin
              if (r_arg < 8'(N_LED)) r_led <= r_led ^ (N_LED'(1) << r_arg[2:0]);
              else                   r_reply <= NAK_BYTE;
            end
            OP_SET:  r_led <= r_arg[N_LED-1:0];
            OP_CLR:  r_led <= r_led & ~r_arg[N_LED-1:0];
`ifdef CMD_READBACK_EN
            OP_READ: r_readback <= 1'b1;
`endif
            default: r_reply <= NAK_BYTE;
          endcase
        end
        ST_TX_REQ: begin
          if (!bus.tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= r_reply;
            r_state    <= ST_TX_WAIT;
          end
        end
        // r_tx_start is high exactly on the cycle before the transmitter reports busy.
        ST_TX_WAIT: begin
          if (!r_tx_start && !bus.tx_busy) begin
`ifdef CMD_READBACK_EN
            r_state <= r_readback ? ST_TX_REQ2 : ST_IDLE;
`else
            r_state <= ST_IDLE;
`endif
          end
        end
`ifdef CMD_READBACK_EN
        ST_TX_REQ2: begin
          if (!bus.tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= 8'(r_led);
            r_state    <= ST_TX_WAIT2;
          end
        end
        ST_TX_WAIT2: begin
          if (!r_tx_start && !bus.tx_busy) begin
            r_readback <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_start  = r_tx_start;
  assign bus.tx_data   = r_tx_data;
  assign bus.led       = r_led;
  assign bus.frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_uart_cmd_ctrl                                                     |
// | Scoreboard bench for uart_cmd_ctrl with a simple transmitter model.  |
// | Build option: CMD_READBACK_EN selects the readback expectations.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_cmd_ctrl;

  localparam int N_LED    = 4;
  localparam int TIMEOUT  = 100;
  localparam int BUSY_LEN = 8;

  logic clk;
  logic rst_n;
  logic hold_busy;

  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_pass;
  int         n_tx;
  int         n_fe;
  int         exp_tx;
  int         exp_fe;

  uart_cmd_ctrl_if #(.N_LED(N_LED)) bus ();

  uart_cmd_ctrl #(
    .N_LED          (N_LED),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Transmitter model and output monitor: busy follows each tx_start by one cycle.
  initial begin
    int       busy_left;
    logic [7:0] e;
    busy_left = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        busy_left = 0;
      end else begin
        if (busy_left > 0) busy_left--;
        if (bus.tx_start) begin
          n_tx++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tx_data", {24'h0, bus.tx_data}, {24'h0, e});
          end
          busy_left = BUSY_LEN;
        end
        if (bus.frame_err) n_fe++;
      end
      bus.tx_busy = hold_busy || (busy_left > 0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data      = b;
    bus.rx_done_flag = 1'b1;
    @(posedge clk); #1;
    bus.rx_done_flag = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] opc, input logic [7:0] arg, input logic [7:0] chk);
    send_byte(8'hAA);
    send_byte(opc);
    send_byte(arg);
    send_byte(chk);
  endtask

  task automatic expect_reply(input logic [7:0] b);
    exp_q.push_back(b);
    exp_tx++;
  endtask

  task automatic settle_and_check(input string tag, input logic [N_LED-1:0] led_exp);
    repeat (40) @(posedge clk);
    #1;
    check({tag, "_led"}, 32'(bus.led), 32'(led_exp));
    check({tag, "_ntx"}, n_tx, exp_tx);
    check({tag, "_nfe"}, n_fe, exp_fe);
    check({tag, "_q"}, exp_q.size(), 0);
  endtask

  initial begin
    int prev;
    int k;
    n_checks = 0; n_pass = 0; n_tx = 0; n_fe = 0; exp_tx = 0; exp_fe = 0;
    hold_busy = 1'b0;
    bus.tx_busy = 1'b0;
    // Flag already high with 0xAA across reset release must not count as a byte.
    bus.rx_done_flag = 1'b1;
    bus.rx_data      = 8'hAA;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", 32'(bus.led), 0);
    check("rst_tx_start", 32'(bus.tx_start), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_frame_err", 32'(bus.frame_err), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.rx_done_flag = 1'b0;
    repeat (2) @(posedge clk);

    expect_reply(8'h06);
    send_frame(8'h55, 8'h02, 8'h57);
    settle_and_check("toggle", 4'b0100);

    expect_reply(8'h06);
    send_frame(8'h01, 8'h0F, 8'h0E);
    settle_and_check("set", 4'b1111);

    expect_reply(8'h06);
    send_frame(8'h02, 8'h05, 8'h07);
    settle_and_check("clr", 4'b1010);

    exp_fe++;
    send_frame(8'h01, 8'h0F, 8'h00);
    settle_and_check("badchk", 4'b1010);

    expect_reply(8'h15);
    send_frame(8'h55, 8'h07, 8'h52);
    settle_and_check("badidx", 4'b1010);

`ifdef CMD_READBACK_EN
    expect_reply(8'h06);
    expect_reply(8'h0A);
`else
    expect_reply(8'h15);
`endif
    send_frame(8'h03, 8'h00, 8'h03);
    settle_and_check("read", 4'b1010);

    send_byte(8'hAA);
    send_byte(8'h01);
    repeat (TIMEOUT + 20) @(posedge clk);
    #1;
    exp_fe++;
    check("timeout_nfe", n_fe, exp_fe);
    expect_reply(8'h06);
    send_frame(8'h01, 8'h03, 8'h02);
    settle_and_check("post_to", 4'b0011);

    hold_busy = 1'b1;
    prev = n_tx;
    expect_reply(8'h06);
    send_frame(8'h01, 8'h0C, 8'h0D);
    repeat (20) @(posedge clk);
    #1;
    check("busy_hold_ntx", n_tx, prev);
    check("busy_led", 32'(bus.led), 32'(4'b1100));
    hold_busy = 1'b0;
    k = 0;
    while (n_tx == prev && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("busy_release_ntx", n_tx, prev + 1);
    send_byte(8'hAA);
    settle_and_check("drop", 4'b1100);

    expect_reply(8'h06);
    send_frame(8'h02, 8'h04, 8'h06);
    settle_and_check("after_drop", 4'b1000);

    send_byte(8'hAA);
    send_byte(8'h01);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_led", 32'(bus.led), 0);
    check("midrst_tx_data", 32'(bus.tx_data), 0);
    check("midrst_tx_start", 32'(bus.tx_start), 0);
    check("midrst_frame_err", 32'(bus.frame_err), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    expect_reply(8'h06);
    send_frame(8'h55, 8'h00, 8'h55);
    settle_and_check("post_rst", 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
